// File: rtl/reg8file_arbiter.sv
// Two-requester access controller for the 8x8 register file: round-robin (or fixed
// priority) arbitration of single read/write transactions plus a sequenced global clear.
module reg8file_arbiter #(
    parameter int DW         = 8,
    parameter int AW         = 3,
    parameter int FIXED_PRIO = 0
) (
    input  logic          clk,
    input  logic          clr_n,
    input  logic          req_a,
    input  logic          we_a,
    input  logic [AW-1:0] addr_a,
    input  logic [DW-1:0] wdata_a,
    output logic          ack_a,
    output logic [DW-1:0] rdata_a,
    input  logic          req_b,
    input  logic          we_b,
    input  logic [AW-1:0] addr_b,
    input  logic [DW-1:0] wdata_b,
    output logic          ack_b,
    output logic [DW-1:0] rdata_b,
    input  logic          clear_req,
    output logic          clear_ack,
    output logic          busy,
    output logic          rf_clr,
    output logic          rf_en,
    output logic [AW-1:0] rf_wsel,
    output logic [AW-1:0] rf_rsel,
    output logic [DW-1:0] rf_d,
    input  logic [DW-1:0] rf_q
);

    typedef enum logic [2:0] {IDLE, XFER, ACK, CLEAR, CLRACK} state_t;

    state_t        state, next_state;
    logic          gsel;        // 0 = A, 1 = B
    logic          last_grant;  // 0 = A, 1 = B
    logic          grant_b;
    logic          cur_we;
    logic [AW-1:0] cur_addr;
    logic [DW-1:0] cur_wdata;

    // On a tie the requester that did not win last time gets the port.
    always_comb begin
        grant_b = req_b;
        if (req_a && req_b)
            grant_b = (FIXED_PRIO != 0) ? 1'b0 : ~last_grant;
    end

    assign cur_we    = gsel ? we_b    : we_a;
    assign cur_addr  = gsel ? addr_b  : addr_a;
    assign cur_wdata = gsel ? wdata_b : wdata_a;

    always_ff @(posedge clk) begin
        if (!clr_n) begin
            state      <= IDLE;
            gsel       <= 1'b0;
            last_grant <= 1'b1;
            rdata_a    <= '0;
            rdata_b    <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && next_state == XFER)
                gsel <= grant_b;
            if (state == XFER) begin
                last_grant <= gsel;
                if (!cur_we) begin
                    if (gsel)
                        rdata_b <= rf_q;
                    else
                        rdata_a <= rf_q;
                end
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (clear_req)
                    next_state = CLEAR;
                else if (req_a || req_b)
                    next_state = XFER;
            end
            XFER:    next_state = ACK;
            ACK:     next_state = IDLE;
            CLEAR:   next_state = CLRACK;
            CLRACK:  next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // While clr_n is low every output except rf_clr is held idle, so a write cut
    // short by reset never reaches the file and no ack escapes.
    always_comb begin
        ack_a     = 1'b0;
        ack_b     = 1'b0;
        clear_ack = 1'b0;
        busy      = 1'b0;
        rf_clr    = ~clr_n;
        rf_en     = 1'b0;
        rf_wsel   = '0;
        rf_rsel   = '0;
        rf_d      = '0;
        if (clr_n) begin
            busy = (state != IDLE);
            case (state)
                XFER: begin
                    if (cur_we) begin
                        rf_en   = 1'b1;
                        rf_wsel = cur_addr;
                        rf_d    = cur_wdata;
                    end else begin
                        rf_rsel = cur_addr;
                    end
                end
                ACK: begin
                    ack_a = ~gsel;
                    ack_b = gsel;
                end
                CLEAR:   rf_clr    = 1'b1;
                CLRACK:  clear_ack = 1'b1;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_reg8file_arbiter.sv
// Directed bench for reg8file_arbiter: a round-robin and a fixed-priority instance share
// stimulus, each driving its own behavioural 8x8 register file.
module tb_reg8file_arbiter;

    logic       clk = 1'b0;
    logic       clr_n;
    logic       req_a, we_a, req_b, we_b, clear_req;
    logic [2:0] addr_a, addr_b;
    logic [7:0] wdata_a, wdata_b;

    logic       ack_a, ack_b, clear_ack, busy, rf_clr, rf_en;
    logic [7:0] rdata_a, rdata_b, rf_d, rf_q;
    logic [2:0] rf_wsel, rf_rsel;

    logic       ack_a1, ack_b1, clear_ack1, busy1, rf_clr1, rf_en1;
    logic [7:0] rdata_a1, rdata_b1, rf_d1, rf_q1;
    logic [2:0] rf_wsel1, rf_rsel1;

    logic [7:0] mem0 [8];
    logic [7:0] mem1 [8];

    int checks = 0;
    int passed = 0;

    always #5 clk = ~clk;

    reg8file_arbiter #(.DW(8), .AW(3), .FIXED_PRIO(0)) dut (
        .clk(clk), .clr_n(clr_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .ack_a(ack_a), .rdata_a(rdata_a),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_b(ack_b), .rdata_b(rdata_b),
        .clear_req(clear_req), .clear_ack(clear_ack), .busy(busy),
        .rf_clr(rf_clr), .rf_en(rf_en), .rf_wsel(rf_wsel), .rf_rsel(rf_rsel),
        .rf_d(rf_d), .rf_q(rf_q)
    );

    reg8file_arbiter #(.DW(8), .AW(3), .FIXED_PRIO(1)) dut_fixed (
        .clk(clk), .clr_n(clr_n),
        .req_a(req_a), .we_a(we_a), .addr_a(addr_a), .wdata_a(wdata_a),
        .ack_a(ack_a1), .rdata_a(rdata_a1),
        .req_b(req_b), .we_b(we_b), .addr_b(addr_b), .wdata_b(wdata_b),
        .ack_b(ack_b1), .rdata_b(rdata_b1),
        .clear_req(clear_req), .clear_ack(clear_ack1), .busy(busy1),
        .rf_clr(rf_clr1), .rf_en(rf_en1), .rf_wsel(rf_wsel1), .rf_rsel(rf_rsel1),
        .rf_d(rf_d1), .rf_q(rf_q1)
    );

    // Behavioural register files: synchronous clear wins over a write in the same cycle.
    always @(posedge clk) begin
        if (rf_clr) begin
            for (int i = 0; i < 8; i++) mem0[i] <= 8'h00;
        end else if (rf_en) begin
            mem0[rf_wsel] <= rf_d;
        end
        if (rf_clr1) begin
            for (int j = 0; j < 8; j++) mem1[j] <= 8'h00;
        end else if (rf_en1) begin
            mem1[rf_wsel1] <= rf_d1;
        end
    end

    assign rf_q  = mem0[rf_rsel];
    assign rf_q1 = mem1[rf_rsel1];

    task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual === expected)
            passed++;
        else
            $display("[TB] FAIL %s: got %0h, expected %0h (t=%0t)", tag, actual, expected, $time);
    endtask

    task automatic applyStimulus(input logic ra, input logic wa, input logic [2:0] aa, input logic [7:0] da,
                                 input logic rb, input logic wb, input logic [2:0] ab, input logic [7:0] db,
                                 input logic clr);
        req_a = ra; we_a = wa; addr_a = aa; wdata_a = da;
        req_b = rb; we_b = wb; addr_b = ab; wdata_b = db;
        clear_req = clr;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        applyStimulus(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
        clr_n = 1'b0;
        tick();
        tick();
        clr_n = 1'b1;
        tick();
    endtask

    // One full transaction from IDLE: XFER, ACK (acks checked), back to IDLE.
    task automatic runTxn(input string tag, input logic ea, input logic eb, input logic ea1, input logic eb1);
        tick();
        tick();
        checkOutput({tag, "_ack_a"}, {31'b0, ack_a}, {31'b0, ea});
        checkOutput({tag, "_ack_b"}, {31'b0, ack_b}, {31'b0, eb});
        checkOutput({tag, "_fx_ack_a"}, {31'b0, ack_a1}, {31'b0, ea1});
        checkOutput({tag, "_fx_ack_b"}, {31'b0, ack_b1}, {31'b0, eb1});
        tick();
    endtask

    initial begin
        applyStimulus(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
        clr_n = 1'b0;
        tick();
        tick();
        checkOutput("rst_rf_clr",    {31'b0, rf_clr},    32'd1);
        checkOutput("rst_ack_a",     {31'b0, ack_a},     32'd0);
        checkOutput("rst_ack_b",     {31'b0, ack_b},     32'd0);
        checkOutput("rst_clear_ack", {31'b0, clear_ack}, 32'd0);
        checkOutput("rst_busy",      {31'b0, busy},      32'd0);
        checkOutput("rst_rdata_a",   {24'b0, rdata_a},   32'h00);
        checkOutput("rst_rdata_b",   {24'b0, rdata_b},   32'h00);
        checkOutput("rst_rf_en",     {31'b0, rf_en},     32'd0);
        clr_n = 1'b1;
        tick();
        checkOutput("idle_busy",   {31'b0, busy},   32'd0);
        checkOutput("idle_rf_clr", {31'b0, rf_clr}, 32'd0);

        // A writes FF to addr 1 then reads it back.
        applyStimulus(1, 1, 3'd1, 8'hFF, 0, 0, 3'd0, 8'h00, 0);
        tick();
        checkOutput("wr_rf_en",   {31'b0, rf_en},   32'd1);
        checkOutput("wr_rf_wsel", {29'b0, rf_wsel}, 32'd1);
        checkOutput("wr_rf_d",    {24'b0, rf_d},    32'hFF);
        checkOutput("wr_busy",    {31'b0, busy},    32'd1);
        checkOutput("wr_noack",   {31'b0, ack_a},   32'd0);
        tick();
        checkOutput("wr_ack_a", {31'b0, ack_a}, 32'd1);
        checkOutput("wr_ack_b", {31'b0, ack_b}, 32'd0);
        applyStimulus(1, 0, 3'd1, 8'h00, 0, 0, 3'd0, 8'h00, 0);
        tick();
        checkOutput("c3_ack_a", {31'b0, ack_a}, 32'd0);
        checkOutput("c3_busy",  {31'b0, busy},  32'd0);
        tick();
        checkOutput("rd_rf_en",   {31'b0, rf_en},   32'd0);
        checkOutput("rd_rf_rsel", {29'b0, rf_rsel}, 32'd1);
        tick();
        checkOutput("rd_ack_a",   {31'b0, ack_a},   32'd1);
        checkOutput("rd_rdata_a", {24'b0, rdata_a}, 32'hFF);
        applyStimulus(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
        tick();

        // Tie from reset: A wins, its write is visible to B's read next.
        doReset();
        applyStimulus(1, 1, 3'd7, 8'h02, 1, 0, 3'd7, 8'h00, 0);
        tick();
        checkOutput("tie_rf_en",   {31'b0, rf_en},   32'd1);
        checkOutput("tie_rf_wsel", {29'b0, rf_wsel}, 32'd7);
        checkOutput("tie_rf_d",    {24'b0, rf_d},    32'h02);
        tick();
        checkOutput("tie_ack_a", {31'b0, ack_a}, 32'd1);
        checkOutput("tie_ack_b", {31'b0, ack_b}, 32'd0);
        applyStimulus(0, 0, 3'd0, 8'h00, 1, 0, 3'd7, 8'h00, 0);
        tick();
        tick();
        checkOutput("tieb_rf_rsel", {29'b0, rf_rsel}, 32'd7);
        tick();
        checkOutput("tieb_ack_b",   {31'b0, ack_b},   32'd1);
        checkOutput("tieb_rdata_b", {24'b0, rdata_b}, 32'h02);
        applyStimulus(1, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
        tick();
        runTxn("solo_a", 1, 0, 1, 0);
        // Both held: round-robin alternates B, A, B; fixed priority always picks A.
        applyStimulus(1, 0, 3'd7, 8'h00, 1, 0, 3'd0, 8'h00, 0);
        runTxn("rr1", 0, 1, 1, 0);
        runTxn("rr2", 1, 0, 1, 0);
        checkOutput("rr2_rdata_a", {24'b0, rdata_a}, 32'h02);
        runTxn("rr3", 0, 1, 1, 0);
        applyStimulus(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
        tick();

        // Clear beats both requesters.
        doReset();
        applyStimulus(1, 1, 3'd1, 8'hFF, 0, 0, 3'd0, 8'h00, 0);
        runTxn("fill", 1, 0, 1, 0);
        applyStimulus(0, 0, 3'd0, 8'h00, 1, 0, 3'd1, 8'h00, 0);
        runTxn("prerd", 0, 1, 0, 1);
        checkOutput("prerd_rdata_b", {24'b0, rdata_b}, 32'hFF);
        applyStimulus(1, 0, 3'd1, 8'h00, 1, 0, 3'd1, 8'h00, 1);
        tick();
        checkOutput("clr_rf_clr", {31'b0, rf_clr}, 32'd1);
        checkOutput("clr_rf_en",  {31'b0, rf_en},  32'd0);
        checkOutput("clr_busy",   {31'b0, busy},   32'd1);
        checkOutput("clr_ack_a",  {31'b0, ack_a},  32'd0);
        tick();
        checkOutput("clrack",        {31'b0, clear_ack}, 32'd1);
        checkOutput("clrack_rf_clr", {31'b0, rf_clr},    32'd0);
        clear_req = 1'b0;
        tick();
        checkOutput("clrack_drop", {31'b0, clear_ack}, 32'd0);
        runTxn("postclr1", 1, 0, 1, 0);
        checkOutput("postclr_rdata_a", {24'b0, rdata_a}, 32'h00);
        runTxn("postclr2", 0, 1, 1, 0);
        checkOutput("postclr_rdata_b", {24'b0, rdata_b}, 32'h00);
        applyStimulus(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
        tick();

        // Reset during a write's XFER: no ack, write lost, file cleared.
        doReset();
        applyStimulus(1, 1, 3'd2, 8'h55, 0, 0, 3'd0, 8'h00, 0);
        runTxn("w55", 1, 0, 1, 0);
        applyStimulus(1, 0, 3'd2, 8'h00, 0, 0, 3'd0, 8'h00, 0);
        runTxn("r55", 1, 0, 1, 0);
        checkOutput("r55_rdata_a", {24'b0, rdata_a}, 32'h55);
        applyStimulus(1, 1, 3'd3, 8'hAA, 0, 0, 3'd0, 8'h00, 0);
        tick();
        checkOutput("wAA_rf_wsel", {29'b0, rf_wsel}, 32'd3);
        clr_n = 1'b0;
        applyStimulus(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
        #1;
        checkOutput("abort_rf_en",  {31'b0, rf_en},  32'd0);
        checkOutput("abort_rf_clr", {31'b0, rf_clr}, 32'd1);
        tick();
        checkOutput("abort_ack_a", {31'b0, ack_a}, 32'd0);
        checkOutput("abort_busy",  {31'b0, busy},  32'd0);
        clr_n = 1'b1;
        tick();
        checkOutput("abort_ack_a2", {31'b0, ack_a}, 32'd0);
        applyStimulus(1, 0, 3'd3, 8'h00, 0, 0, 3'd0, 8'h00, 0);
        runTxn("rd3", 1, 0, 1, 0);
        checkOutput("rd3_rdata_a", {24'b0, rdata_a}, 32'h00);
        applyStimulus(1, 0, 3'd2, 8'h00, 0, 0, 3'd0, 8'h00, 0);
        runTxn("rd2", 1, 0, 1, 0);
        checkOutput("rd2_rdata_a", {24'b0, rdata_a}, 32'h00);
        applyStimulus(0, 0, 3'd0, 8'h00, 0, 0, 3'd0, 8'h00, 0);
        tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
